lvds_sync_decoder: RTL and testbench
====================================

LVDS_SYNC_DECODER -- requirements
Module: lvds_sync_decoder

Interface
REQ-001 Parameter LINE_PIXELS, default 1280: required active pixels per line; range 1..4092.
REQ-002 Parameter FRAME_LINES, default 960: required lines per frame; range 1..4095.
REQ-003 Port clk, input, 1: single clock (deserializer divided-clock domain); all logic on rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port data_in, input, 12: deserialized parallel word.
REQ-006 Port data_valid, input, 1: data_in accepted on each clk edge where high.
REQ-007 Port pixel_out, output, 12: active pixel word.
REQ-008 Port pixel_valid, output, 1: one-cycle qualifier for pixel_out.
REQ-009 Port line_start, output, 1: high together with pixel_valid for the first pixel of each line.
REQ-010 Port frame_start / frame_end, output, 1 each: one-cycle pulses on SOF / EOF decode.
REQ-011 Port pixel_count, output, 12: pixels emitted in current line.
REQ-012 Port line_count, output, 12: lines completed in current frame.
REQ-013 Port locked, output, 1: high between a valid SOF and the next sync error.
REQ-014 Port sync_err, output, 1: one-cycle pulse per detected protocol error.

Function
REQ-015 Window: 4-slot shift register w0 (newest)..w3 (oldest), each slot carrying a 12-bit word plus tag bits {pix, first}; shifts only when data_valid=1.
REQ-016 On each accepted word: w0<=data_in, wN<=wN-1; the previous w3 is emitted next cycle (pixel_out=old w3, pixel_valid=old w3.pix, line_start=old w3.first).
REQ-017 Latency: a pixel accepted at valid-beat k appears on pixel_out one clk after valid-beat k+4; data_valid=0 cycles stall the pipeline, and pixel_valid is then 0.
REQ-018 Incoming tag: pix=1 iff locked=1 and state=ACTIVE; first=1 on the first tagged word after an SOF/SOL.
REQ-019 Sync match: data_valid=1 and w2=12'hFFF, w1=12'h000, w0=12'h000; data_in is the code word.
REQ-020 On a sync match, after the shift, tags of new w0..w3 (code + preamble) are cleared, so the preamble is never emitted; old w3 still emits normally.
REQ-021 Code decode: data_in[7:0] must be 8'h00; data_in[11:8]: 8=SOL, 9=EOL, A=SOF, B=EOF; anything else is invalid.
REQ-022 States: BLANK, ACTIVE; reset to BLANK.
REQ-023 SOF: frame_start pulse, line_count<=0, locked<=1, -> ACTIVE (first line starts).
REQ-024 SOL in BLANK: -> ACTIVE; SOL in ACTIVE: sync_err (missing EOL), line restarts, stays ACTIVE.
REQ-025 EOL in ACTIVE: -> BLANK; line_count+1 (saturating at 4095); sync_err if in_cnt-3 != LINE_PIXELS, where in_cnt counts words accepted in ACTIVE since line start, excluding the code word.
REQ-026 EOL in BLANK: sync_err, state unchanged.
REQ-027 EOF: frame_end pulse, -> BLANK; sync_err if line_count != FRAME_LINES (count after any same-beat update).
REQ-028 Invalid code: sync_err, locked<=0, -> BLANK, all window tags cleared.
REQ-029 Before the first SOF (locked=0), SOL/EOL/EOF are decoded for state only and no pixels are tagged.
REQ-030 pixel_count: cleared in the cycle line_start is asserted, then counts to 1 on that pixel; +1 per pixel_valid; saturates at 4095; held otherwise.
REQ-031 Pixel data equal to FFF or 000 not forming the full 4-word sync pattern is passed through unchanged.

Reset
REQ-032 While rst=1: all outputs 0, state BLANK, window words and tags 0, in_cnt 0, locked 0; takes priority over data_valid, including mid-line.
REQ-033 The first accepted word after rst deasserts is treated like any other word; no pixel is emitted until a full SOF has been received.

Verification
REQ-034 SOF, 4 pixels 0x001..0x004, EOL with LINE_PIXELS=4 -> pixel_out 001..004 with pixel_valid, line_start on 001, pixel_count=4, line_count=1, no sync_err, no FFF/000 emitted.
REQ-035 Same line with data_valid toggling every other cycle -> identical pixel sequence, pixel_valid only on the cycle after a shift.
REQ-036 Pixel payload FFF,000,123 inside a line -> all three emitted, no sync detected.
REQ-037 Line of 3 pixels with LINE_PIXELS=4 -> single sync_err pulse at the EOL beat, state BLANK.
REQ-038 Code word 0xC00 after a valid preamble -> sync_err, locked=0, subsequent pixels not emitted until the next SOF.
REQ-039 rst asserted mid-line for 1 cycle -> all outputs 0 the next cycle; following SOL without SOF emits nothing.

Source files
------------

// File: rtl/lvds_sync_decoder_if.sv
// Parallel-word input and decoded video output bundle for lvds_sync_decoder.
// The master side drives deserialized words; the slave side is the decoder.
interface lvds_sync_decoder_if;
    logic [11:0] data_in;
    logic        data_valid;
    logic [11:0] pixel_out;
    logic        pixel_valid;
    logic        line_start;
    logic        frame_start;
    logic        frame_end;
    logic [11:0] pixel_count;
    logic [11:0] line_count;
    logic        locked;
    logic        sync_err;

    modport master (
        output data_in, data_valid,
        input  pixel_out, pixel_valid, line_start, frame_start, frame_end,
        input  pixel_count, line_count, locked, sync_err
    );

    modport slave (
        input  data_in, data_valid,
        output pixel_out, pixel_valid, line_start, frame_start, frame_end,
        output pixel_count, line_count, locked, sync_err
    );
endinterface

// File: rtl/lvds_sync_decoder.sv
// Embedded-sync decoder: a 4-word window delays the stream so that the FFF/000/000 preamble
// of a sync code can be stripped before it leaves, while line/frame timing is checked.
module lvds_sync_decoder #(
    parameter int unsigned LINE_PIXELS = 1280,
    parameter int unsigned FRAME_LINES = 960
) (
    input logic                clk,
    input logic                rst,
    lvds_sync_decoder_if.slave bus_io
);

    typedef enum logic {StBlank, StActive} state_e;

    typedef struct packed {
        logic [11:0] word;
        logic        pix;
        logic        first;
    } slot_t;

    // A complete line holds the pixels plus the three preamble words of its EOL.
    localparam logic [11:0] LineWords  = 12'(LINE_PIXELS + 3);
    localparam logic [11:0] FrameLines = 12'(FRAME_LINES);
    localparam logic [11:0] CntMax     = 12'hFFF;
    localparam logic [3:0]  CodeSol    = 4'h8;
    localparam logic [3:0]  CodeEol    = 4'h9;
    localparam logic [3:0]  CodeSof    = 4'hA;
    localparam logic [3:0]  CodeEof    = 4'hB;

    state_e      state_q, state_d;
    slot_t [3:0] win_q, win_d;
    slot_t       in_slot;
    logic        locked_q, locked_d;
    logic        first_pend_q, first_pend_d;
    logic [11:0] in_cnt_q, in_cnt_d;
    logic [11:0] line_cnt_q, line_cnt_d;
    logic [11:0] pix_cnt_q, pix_cnt_d;
    logic [11:0] pixel_out_q, pixel_out_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_end_q, frame_end_d;
    logic        sync_err_q, sync_err_d;
    logic        active;
    logic        sync_hit;
    logic        err;

    function automatic logic [11:0] sat_inc(logic [11:0] v);
        return (v == CntMax) ? v : v + 12'd1;
    endfunction

    assign active   = (state_q == StActive);
    assign sync_hit = bus_io.data_valid && (win_q[2].word == 12'hFFF) &&
                      (win_q[1].word == 12'h000) && (win_q[0].word == 12'h000);

    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        locked_d      = locked_q;
        first_pend_d  = first_pend_q;
        in_cnt_d      = in_cnt_q;
        line_cnt_d    = line_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        pixel_out_d   = pixel_out_q;
        pixel_valid_d = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        sync_err_d    = 1'b0;
        err           = 1'b0;

        in_slot.word  = bus_io.data_in;
        in_slot.pix   = locked_q && active;
        in_slot.first = locked_q && active && first_pend_q;

        if (bus_io.data_valid) begin
            win_d         = {win_q[2:0], in_slot};
            pixel_out_d   = win_q[3].word;
            pixel_valid_d = win_q[3].pix;
            line_start_d  = win_q[3].first;
            if (win_q[3].pix) begin
                pix_cnt_d = win_q[3].first ? 12'd1 : sat_inc(pix_cnt_q);
            end

            if (!sync_hit) begin
                if (in_slot.first) begin
                    first_pend_d = 1'b0;
                end
                if (active) begin
                    in_cnt_d = sat_inc(in_cnt_q);
                end
            end else begin
                // Code word and preamble now occupy the whole window; none of it is video.
                for (int i = 0; i < 4; i++) begin
                    win_d[i].pix   = 1'b0;
                    win_d[i].first = 1'b0;
                end

                if (bus_io.data_in[7:0] != 8'h00) begin
                    err     = 1'b1;
                    state_d = StBlank;
                end else begin
                    case (bus_io.data_in[11:8])
                        CodeSof: begin
                            frame_start_d = 1'b1;
                            line_cnt_d    = '0;
                            locked_d      = 1'b1;
                            state_d       = StActive;
                            first_pend_d  = 1'b1;
                            in_cnt_d      = '0;
                        end
                        CodeSol: begin
                            if (active && locked_q) begin
                                err = 1'b1;
                            end
                            state_d      = StActive;
                            first_pend_d = 1'b1;
                            in_cnt_d     = '0;
                        end
                        CodeEol: begin
                            if (active) begin
                                state_d = StBlank;
                                if (locked_q) begin
                                    line_cnt_d = sat_inc(line_cnt_q);
                                    if (in_cnt_q != LineWords) begin
                                        err = 1'b1;
                                    end
                                end
                            end else if (locked_q) begin
                                err = 1'b1;
                            end
                        end
                        CodeEof: begin
                            state_d = StBlank;
                            if (locked_q) begin
                                frame_end_d = 1'b1;
                                if (line_cnt_q != FrameLines) begin
                                    err = 1'b1;
                                end
                            end
                        end
                        default: begin
                            err     = 1'b1;
                            state_d = StBlank;
                        end
                    endcase
                end
            end
        end

        // Any protocol error drops lock; only a fresh SOF restores it.
        if (err) begin
            sync_err_d = 1'b1;
            locked_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StBlank;
            win_q         <= '0;
            locked_q      <= 1'b0;
            first_pend_q  <= 1'b0;
            in_cnt_q      <= '0;
            line_cnt_q    <= '0;
            pix_cnt_q     <= '0;
            pixel_out_q   <= '0;
            pixel_valid_q <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            locked_q      <= locked_d;
            first_pend_q  <= first_pend_d;
            in_cnt_q      <= in_cnt_d;
            line_cnt_q    <= line_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            pixel_out_q   <= pixel_out_d;
            pixel_valid_q <= pixel_valid_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign bus_io.pixel_out   = pixel_out_q;
    assign bus_io.pixel_valid = pixel_valid_q;
    assign bus_io.line_start  = line_start_q;
    assign bus_io.frame_start = frame_start_q;
    assign bus_io.frame_end   = frame_end_q;
    assign bus_io.pixel_count = pix_cnt_q;
    assign bus_io.line_count  = line_cnt_q;
    assign bus_io.locked      = locked_q;
    assign bus_io.sync_err    = sync_err_q;

endmodule

// File: tb/tb_lvds_sync_decoder.sv
// Directed and randomized sync-stream bench for lvds_sync_decoder, checked each cycle against a
// stream-level reference model built from the protocol rules.
module tb_lvds_sync_decoder;

    localparam int unsigned LP = 4;
    localparam int unsigned FL = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lvds_sync_decoder_if bus ();

    lvds_sync_decoder #(
        .LINE_PIXELS(LP),
        .FRAME_LINES(FL)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    typedef struct {
        logic [11:0] word;
        bit          pix;
        bit          first;
    } ent_t;

    // Reference model: accepted-word history plus protocol state.
    ent_t        strm[$];
    bit          m_locked, m_active, m_first_pend;
    int          m_words, m_lines, m_pcnt;
    logic [11:0] e_out;
    bit          e_pv, e_ls, e_fs, e_fe, e_err;

    int n_pass   = 0;
    int n_checks = 0;
    int gap_mode = 0;

    function automatic int sat(int v);
        return (v > 4095) ? 4095 : v;
    endfunction

    function automatic void model_reset();
        strm.delete();
        m_locked = 0; m_active = 0; m_first_pend = 0;
        m_words = 0; m_lines = 0; m_pcnt = 0;
        e_out = '0; e_pv = 0; e_ls = 0; e_fs = 0; e_fe = 0; e_err = 0;
    endfunction

    function automatic void model_decode(logic [11:0] din);
        bit err = 0;
        if (din[7:0] != 8'h00) begin
            err = 1; m_active = 0;
        end else begin
            case (din[11:8])
                4'hA: begin
                    e_fs = 1; m_lines = 0; m_locked = 1; m_active = 1;
                    m_first_pend = 1; m_words = 0;
                end
                4'h8: begin
                    if (m_active && m_locked) err = 1;
                    m_active = 1; m_first_pend = 1; m_words = 0;
                end
                4'h9: begin
                    if (m_active) begin
                        m_active = 0;
                        if (m_locked) begin
                            m_lines = sat(m_lines + 1);
                            if (m_words - 3 != int'(LP)) err = 1;
                        end
                    end else if (m_locked) begin
                        err = 1;
                    end
                end
                4'hB: begin
                    m_active = 0;
                    if (m_locked) begin
                        e_fe = 1;
                        if (m_lines != int'(FL)) err = 1;
                    end
                end
                default: begin
                    err = 1; m_active = 0;
                end
            endcase
        end
        if (err) begin
            e_err = 1; m_locked = 0;
        end
    endfunction

    function automatic void model_step(bit dv, logic [11:0] din);
        ent_t e;
        int   n;
        bit   hit;
        e_pv = 0; e_ls = 0; e_fs = 0; e_fe = 0; e_err = 0;
        if (!dv) return;
        n   = strm.size();
        hit = (n >= 3) && (strm[n-3].word == 12'hFFF) && (strm[n-2].word == 12'h000) &&
              (strm[n-1].word == 12'h000);
        e.word  = din;
        e.pix   = m_locked && m_active;
        e.first = e.pix && m_first_pend;
        // Each word leaves four accepted words after it arrived.
        if (n >= 4) begin
            e_out = strm[n-4].word; e_pv = strm[n-4].pix; e_ls = strm[n-4].first;
        end else begin
            e_out = '0;
        end
        if (e_pv) m_pcnt = e_ls ? 1 : sat(m_pcnt + 1);
        strm.push_back(e);
        if (!hit) begin
            if (e.first) m_first_pend = 0;
            if (m_active) m_words = sat(m_words + 1);
        end else begin
            for (int i = n - 3; i <= n; i++) begin
                strm[i].pix = 0; strm[i].first = 0;
            end
            model_decode(din);
        end
        while (strm.size() > 8) void'(strm.pop_front());
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("pixel_valid", 32'(bus.pixel_valid), 32'(e_pv));
        chk("pixel_out", 32'(bus.pixel_out), 32'(e_out));
        chk("line_start", 32'(bus.line_start), 32'(e_ls));
        chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
        chk("frame_end", 32'(bus.frame_end), 32'(e_fe));
        chk("sync_err", 32'(bus.sync_err), 32'(e_err));
        chk("pixel_count", 32'(bus.pixel_count), 32'(m_pcnt));
        chk("line_count", 32'(bus.line_count), 32'(m_lines));
        chk("locked", 32'(bus.locked), 32'(m_locked));
    endtask

    task automatic cycle(bit r, bit dv, logic [11:0] din);
        rst = r;
        bus.data_valid = dv;
        bus.data_in = din;
        @(posedge clk);
        if (r) model_reset();
        else model_step(dv, din);
        #1;
        check_all();
    endtask

    task automatic send(logic [11:0] w);
        int idle;
        idle = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (idle) cycle(0, 0, 12'($urandom));
        cycle(0, 1, w);
    endtask

    task automatic sync(logic [11:0] code);
        send(12'hFFF); send(12'h000); send(12'h000); send(code);
    endtask

    task automatic line(int npix);
        for (int i = 0; i < npix; i++) send(12'($urandom_range(1, 12'hFFE)));
    endtask

    initial begin
        logic [11:0] codes[6];
        int          nl, np;
        codes = '{12'h800, 12'h900, 12'hA00, 12'hB00, 12'hC00, 12'h703};
        rst = 1'b1;
        bus.data_valid = 1'b0;
        bus.data_in = '0;
        cycle(1, 1, 12'hFFF);
        cycle(1, 0, 12'h000);

        // Basic frame start and one exact-length line.
        sync(12'hA00);
        for (int i = 1; i <= 4; i++) send(12'(i));
        sync(12'h900);
        repeat (3) cycle(0, 0, 12'h000);

        // Same line with data_valid toggling.
        gap_mode = 1;
        sync(12'h800);
        for (int i = 1; i <= 4; i++) send(12'(i));
        sync(12'h900);

        // Payload that looks like pieces of a preamble.
        gap_mode = 2;
        sync(12'h800);
        send(12'hFFF); send(12'h000); send(12'h123); send(12'h456);
        sync(12'h900);
        sync(12'hB00);

        // Well-formed frame: EOF with the right line count.
        gap_mode = 0;
        sync(12'hA00); line(LP); sync(12'h900);
        sync(12'h800); line(LP); sync(12'h900);
        sync(12'hB00);

        // Short line, then invalid code with pixels suppressed until the next SOF.
        sync(12'hA00); line(3); sync(12'h900);
        sync(12'hA00); line(2); sync(12'hC00);
        line(LP); sync(12'h800); line(LP); sync(12'h900);
        sync(12'hA00); line(LP); sync(12'h900);

        // EOL while blank, SOL while active, nonzero code low byte.
        sync(12'h900);
        sync(12'hA00); line(2); sync(12'h800); line(LP); sync(12'h900);
        sync(12'hA00); sync(12'h805);

        // Reset mid-line, then SOL without SOF.
        sync(12'hA00); line(2);
        cycle(1, 1, 12'h321);
        sync(12'h800); line(LP); sync(12'h900);

        // Overlong line saturates the pixel counter.
        sync(12'hA00); line(4100); sync(12'h900);

        // Random frames with occasional length faults and stray codes.
        for (int f = 0; f < 24; f++) begin
            gap_mode = int'($urandom_range(0, 2));
            sync(12'hA00);
            nl = int'(FL) + (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) - 1 : 0);
            if (nl < 1) nl = 1;
            for (int l = 0; l < nl; l++) begin
                if (l > 0) sync(12'h800);
                np = int'(LP) + (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) - 1 : 0);
                line(np);
                if ($urandom_range(0, 9) == 0) sync(codes[$urandom_range(0, 5)]);
                sync(12'h900);
            end
            sync(12'hB00);
            repeat (2) cycle(0, 0, 12'h000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
